mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8: address width.
REQ-002 SHALL have parameter DW, default 16: data width.
REQ-003 SHALL have parameter LAT, default 2, legal range 1..7: memory access cycles per transfer.
REQ-004 SHALL use one clock, clock; reset is synchronous and active-low, port reset.
REQ-005 SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-006 SHALL have port reset, input, 1 bit: synchronous active-low reset.
REQ-007 SHALL have port f_req, input, 1 bit: fetch request, always a read.
REQ-008 SHALL have port f_addr, input, AW bits: fetch address.
REQ-009 SHALL have port f_rdata, output, DW bits: fetch read data.
REQ-010 SHALL have port f_done, output, 1 bit: fetch completion pulse.
REQ-011 SHALL have port d_req, input, 1 bit: data-port request.
REQ-012 SHALL have port d_rw_, input, 1 bit: 1 = read, 0 = write.
REQ-013 SHALL have port d_addr, input, AW bits: data-port address.
REQ-014 SHALL have port d_wdata, input, DW bits: data-port write data.
REQ-015 SHALL have port d_rdata, output, DW bits: data-port read data.
REQ-016 SHALL have port d_done, output, 1 bit: data-port completion pulse.
REQ-017 SHALL have port m_en, output, 1 bit: memory access enable.
REQ-018 SHALL have port m_rw_, output, 1 bit: memory direction, 1 = read.
REQ-019 SHALL have ports m_addr (output, AW bits), m_wdata (output, DW bits) and m_rdata (input, DW bits): memory address, write data and read data.
REQ-020 SHALL have ports busy (output, 1 bit: transfer in progress) and owner (output, 1 bit: 0 = fetch, 1 = data; valid while busy).

Function
REQ-021 SHALL implement the FSM states IDLE, ACCESS and DONE.
REQ-022 IDLE: when any eligible request is high, SHALL grant it at the clock edge, latch its address, rw_ and wdata, load a counter with LAT and go to ACCESS.
REQ-023 A fetch grant SHALL always latch rw_ = 1.
REQ-024 Arbitration SHALL be round-robin: if both requests are high, the port not served last wins; after reset, last served = data, so fetch wins first.
REQ-025 ACCESS: m_en = 1; m_addr, m_rw_ and m_wdata SHALL equal the latched values and stay stable; the counter SHALL decrement each cycle.
REQ-026 On the last ACCESS cycle (counter = 1), m_rdata SHALL be captured into the owner's rdata register if the transfer is a read; the FSM then goes to DONE.
REQ-027 DONE: the owner's done output SHALL be 1 for exactly this one cycle; m_en = 0.
REQ-028 Latency: a request high in IDLE cycle N SHALL see done high in cycle N+LAT+1.
REQ-029 DONE SHALL arbitrate like IDLE, excluding the port just served, so a pending other request is granted at the same edge (back-to-back, no IDLE bubble).
REQ-030 A port whose req is still high in the cycle after its DONE SHALL be treated as a new request.
REQ-031 Requester inputs SHALL be ignored between grant and done; only the latched values are used.
REQ-032 f_rdata and d_rdata SHALL hold their value until the next read completion on the same port; a write SHALL NOT alter d_rdata.
REQ-033 Outside ACCESS: m_en = 0, m_rw_ = 1, m_addr = 0, m_wdata = 0.
REQ-034 busy SHALL be 1 in ACCESS and DONE; owner SHALL be the latched grant.

Reset
REQ-035 While reset = 0 at a clock edge: state IDLE, counter 0, last served = data.
REQ-036 While reset = 0 at a clock edge, all outputs SHALL be 0 except m_rw_ = 1.
REQ-037 Reset asserted during ACCESS SHALL abort the transfer: m_en = 0 from the next cycle, no done pulse, rdata registers cleared.

Verification (LAT = 2)
REQ-038 Fetch read: f_req = 1, f_addr = 0x10 in cycle 0, m_rdata = 0x1234 -> m_en = 1 with m_addr = 0x10 in cycles 1-2; f_done = 1 and f_rdata = 0x1234 in cycle 3.
REQ-039 Data write: d_req = 1, d_rw_ = 0, d_addr = 0x20, d_wdata = 0xBEEF -> m_rw_ = 0, m_wdata = 0xBEEF in cycles 1-2; d_done = 1 in cycle 3; d_rdata unchanged.
REQ-040 Contention: f_req and d_req both held from reset release -> grant order fetch, data, fetch, data.
REQ-041 Contention timing: the grant to the other port SHALL occur at each DONE edge, with busy continuously 1.
REQ-042 Input stability: change d_addr from 0x20 to 0x30 during ACCESS -> m_addr stays 0x20.
REQ-043 Reset mid-transfer: reset = 0 in cycle 1 of a fetch -> m_en = 0 in cycle 2, f_done never pulses, f_rdata = 0.
REQ-044 After reset mid-transfer, the next request SHALL complete with normal timing.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single fixed-latency memory.
// The fetch port only reads. The data port reads or writes. Each transfer runs IDLE -> ACCESS -> DONE.
module mem_arbiter #(
    parameter int AW  = 8,
    parameter int DW  = 16,
    parameter int LAT = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic [DW-1:0] f_rdata,
    output logic          f_done,
    input  logic          d_req,
    input  logic          d_rw_,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          m_en,
    output logic          m_rw_,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          busy,
    output logic          owner
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam int            CW    = 3;
    localparam logic [CW-1:0] LAT_C = CW'(LAT);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;    // 0 = fetch served last, 1 = data
    logic          owner_q, owner_d;
    logic          rw_q, rw_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] f_rdata_q, f_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    logic elig_f, elig_d, pick_d, can_grant;

    // In DONE the port just served is excluded, so the other port gets the next slot.
    assign elig_f    = f_req && !(state_q == DONE && owner_q == 1'b0);
    assign elig_d    = d_req && !(state_q == DONE && owner_q == 1'b1);
    assign pick_d    = elig_d && (!elig_f || !last_q);
    assign can_grant = (state_q == IDLE || state_q == DONE) && (elig_f || elig_d);

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path through the block can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        owner_d   = owner_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        f_rdata_d = f_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            IDLE, DONE: begin
                if (can_grant) begin
                    owner_d = pick_d;
                    last_d  = pick_d;
                    rw_d    = pick_d ? d_rw_ : 1'b1;
                    addr_d  = pick_d ? d_addr : f_addr;
                    wdata_d = pick_d ? d_wdata : '0;
                    cnt_d   = LAT_C;
                    state_d = ACCESS;
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    if (rw_q) begin
                        if (owner_q) d_rdata_d = m_rdata;
                        else         f_rdata_d = m_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            rw_q      <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            f_rdata_q <= f_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // The memory bus is driven only in ACCESS and parks at neutral values otherwise.
    assign m_en    = (state_q == ACCESS);
    assign m_rw_   = m_en ? rw_q : 1'b1;
    assign m_addr  = m_en ? addr_q : '0;
    assign m_wdata = m_en ? wdata_q : '0;

    assign f_done  = (state_q == DONE) && !owner_q;
    assign d_done  = (state_q == DONE) && owner_q;
    assign busy    = (state_q == ACCESS) || (state_q == DONE);
    assign owner   = owner_q;
    assign f_rdata = f_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with LAT = 2. A scoreboard holds the expected completion of each transfer.
// Each entry gives the port, the read data and the cycle of the done pulse.
module tb_mem_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          f_req, d_req, d_rw_;
    logic [AW-1:0] f_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] f_rdata, d_rdata;
    logic          f_done, d_done;
    logic          m_en, m_rw_;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic          busy, owner;

    typedef struct {
        bit          port;   // 0 = fetch, 1 = data
        logic [15:0] data;   // port rdata expected at the done pulse
        int          due;    // cycle of the done pulse
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
        .clock(clock), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_done(f_done),
        .d_req(d_req), .d_rw_(d_rw_), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .m_en(m_en), .m_rw_(m_rw_), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .busy(busy), .owner(owner)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [15:0] mem_f(input logic [7:0] a);
        return (a == 8'h10) ? 16'h1234 : {a, ~a};
    endfunction

    assign m_rdata = m_en ? mem_f(m_addr) : 16'hDEAD;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Completion monitor: every done pulse must match the oldest scoreboard entry.
    always @(negedge clock) begin
        if (f_done || d_done) begin
            if (f_done && d_done) check("both_done", 1, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", {30'd0, f_done, d_done}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_port", {31'd0, d_done}, {31'd0, mon_e.port});
                check("done_cycle", cyc, mon_e.due);
                check("done_rdata", mon_e.port ? d_rdata : f_rdata, mon_e.data);
            end
        end
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic push(input bit port, input logic [15:0] data, input int due);
        exp_t e;
        e.port = port;
        e.data = data;
        e.due  = due;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b0; f_req = 0; d_req = 0; d_rw_ = 1;
        f_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (3) step();
        check("rst_outputs_zero",
              {f_rdata, d_rdata, f_done, d_done, m_en, busy, owner}, 0);
        check("rst_bus_zero", {m_addr, m_wdata}, 0);
        check("rst_m_rw", m_rw_, 1);

        // Fetch read of 0x10.
        reset = 1'b1;
        step();
        f_req = 1; f_addr = 8'h10;
        push(0, 16'h1234, cyc + LAT + 1);
        step();
        f_req = 0; f_addr = 8'h55;
        check("f_access1", {m_en, m_rw_, busy, owner, m_addr}, {4'b1110, 8'h10});
        step();
        check("f_access2", {m_en, m_rw_, m_addr}, {2'b11, 8'h10});
        step();
        check("f_done_bus", {m_en, m_rw_, busy, m_addr}, {3'b011, 8'h00});
        step();
        check("f_idle", {busy, f_done, f_rdata}, {2'b00, 16'h1234});

        // Data read of 0x20. The address changes mid-transfer and must be ignored.
        d_req = 1; d_rw_ = 1; d_addr = 8'h20;
        push(1, mem_f(8'h20), cyc + LAT + 1);
        step();
        d_req = 0; d_addr = 8'h30;
        check("d_addr_hold1", {owner, m_addr}, {1'b1, 8'h20});
        step();
        check("d_addr_hold2", m_addr, 8'h20);
        repeat (2) step();

        // Data write. d_rdata must keep the value of the last read.
        d_req = 1; d_rw_ = 0; d_addr = 8'h20; d_wdata = 16'hBEEF;
        push(1, mem_f(8'h20), cyc + LAT + 1);
        step();
        d_req = 0; d_wdata = 16'h0000; d_rw_ = 1;
        check("w_access1", {m_en, m_rw_, m_wdata, m_addr}, {2'b10, 16'hBEEF, 8'h20});
        step();
        check("w_access2", {m_rw_, m_wdata}, {1'b0, 16'hBEEF});
        step();
        step();
        check("w_idle_bus", {m_en, m_rw_, m_wdata}, {2'b01, 16'h0000});
        check("w_f_rdata_kept", f_rdata, 16'h1234);

        // Reset clears the rdata registers. Then both ports request from reset release.
        reset = 1'b0;
        repeat (2) step();
        check("rst_rdata_clr", {f_rdata, d_rdata}, 0);
        reset = 1'b1;
        f_req = 1; f_addr = 8'h40;
        d_req = 1; d_rw_ = 1; d_addr = 8'h41;
        n = cyc;
        push(0, mem_f(8'h40), n + 3);
        push(1, mem_f(8'h41), n + 6);
        push(0, mem_f(8'h40), n + 9);
        push(1, mem_f(8'h41), n + 12);
        for (int k = 1; k <= 13; k++) begin
            step();
            if (k == 7)  f_req = 0;
            if (k == 10) d_req = 0;
            if (k <= 12) begin
                check($sformatf("rr_busy_%0d", k), busy, 1);
                check($sformatf("rr_owner_%0d", k), owner, ((k - 1) / 3) % 2);
            end else begin
                check("rr_idle", busy, 0);
            end
        end

        // Reset during the first ACCESS cycle aborts the fetch.
        step();
        f_req = 1; f_addr = 8'h10;
        step();
        f_req = 0;
        check("abort_access", m_en, 1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("abort_m_en", {m_en, busy}, 0);
        check("abort_f_rdata", f_rdata, 0);
        repeat (3) step();
        check("abort_f_rdata_late", f_rdata, 0);

        // The next request after the abort completes with normal timing.
        f_req = 1; f_addr = 8'h33;
        push(0, mem_f(8'h33), cyc + LAT + 1);
        step();
        f_req = 0;
        check("post_abort_addr", {m_en, m_addr}, {1'b1, 8'h33});
        repeat (4) step();

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
